// File: rtl/hamming_pkg.sv
// Shared SEC-DED constants, codeword layout helpers and the reference encoder.
// Position 0 is overall parity; check bits sit at the power-of-two positions.
package hamming_pkg;

  localparam int CW_W   = 39;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 6;

  typedef enum logic [1:0] {
    CLEAN,
    CE_PARITY,
    CE_BIT,
    UE
  } err_class_t;

  typedef struct packed {
    logic [CW_W-1:0]  cw;
    logic [CHK_W-1:0] s;
    logic             p;
  } s1_t;

  function automatic int data_pos(input int i);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int q = 1; q < CW_W; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (n == i) pos = q;
        n++;
      end
    end
    return pos;
  endfunction

  // XOR of the indices of all set bits equals the per-bit syndrome
  function automatic logic [CHK_W-1:0] syndrome(
    input logic [CW_W-1:0] cw
  );
    logic [CHK_W-1:0] s;
    s = '0;
    for (int q = 1; q < CW_W; q++) begin
      if (cw[q]) s = s ^ CHK_W'(q);
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(
    input logic [CW_W-1:0] cw
  );
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = cw[data_pos(i)];
    end
    return d;
  endfunction

  function automatic logic [CW_W-1:0] hamming_encode(
    input logic [DATA_W-1:0] data
  );
    logic [CW_W-1:0]  cw;
    logic [CHK_W-1:0] s;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cw[data_pos(i)] = data[i];
    end
    s = syndrome(cw);
    for (int k = 0; k < CHK_W; k++) begin
      cw[1 << k] = s[k];
    end
    cw[0] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall parity of a 39-bit codeword.
// Shared with the encoder-side checker.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [CHK_W-1:0] s,
  output logic             p
);

  assign s = syndrome(cw);
  assign p = ^cw;

endmodule

// File: rtl/hamming_secded_decode_stage.sv
// Two-stage handshaked SEC-DED decoder with saturating CE/UE counters.
// S1 registers codeword+syndrome, S2 corrects, extracts and holds outputs.
module hamming_secded_decode_stage
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW_W-1:0]   in_codeword,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ce,
  output logic              out_ue,
  output logic [CHK_W-1:0]  out_err_pos,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count
);

  localparam logic [CHK_W-1:0] MAX_POS = CHK_W'(CW_W - 1);

  logic              s1_valid;
  s1_t               s1_q;
  s1_t               s1_d;
  logic [CHK_W-1:0]  syn;
  logic              par;
  logic              en1;
  logic              en2;
  logic              ld2;
  err_class_t        cls;
  logic [CW_W-1:0]   fix_cw;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_ce;
  logic              nxt_ue;
  logic [CHK_W-1:0]  nxt_pos;

  hamming_syndrome u_syn (
    .cw (in_codeword),
    .s  (syn),
    .p  (par)
  );

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;
  assign ld2      = en2 && s1_valid;

  always_comb begin
    s1_d    = '0;
    s1_d.cw = in_codeword;
    s1_d.s  = syn;
    s1_d.p  = par;
  end

  always_comb begin
    cls = UE;
    unique case (1'b1)
      (!s1_q.p && s1_q.s == '0): cls = CLEAN;
      (s1_q.p && s1_q.s == '0):  cls = CE_PARITY;
      (s1_q.p && s1_q.s != '0
        && s1_q.s <= MAX_POS):   cls = CE_BIT;
      default:                   cls = UE;
    endcase
  end

  always_comb begin
    fix_cw  = s1_q.cw;
    nxt_ce  = 1'b0;
    nxt_ue  = 1'b0;
    nxt_pos = '0;
    unique case (cls)
      CE_PARITY: nxt_ce = 1'b1;
      CE_BIT: begin
        fix_cw  = s1_q.cw ^ (CW_W'(1) << s1_q.s);
        nxt_ce  = 1'b1;
        nxt_pos = s1_q.s;
      end
      UE:      nxt_ue = 1'b1;
      default: nxt_ce = 1'b0;
    endcase
    nxt_data = extract(fix_cw);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ce      <= 1'b0;
      out_ue      <= 1'b0;
      out_err_pos <= '0;
    end else begin
      if (en1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (en2) out_valid <= s1_valid;
      if (ld2) begin
        out_data    <= nxt_data;
        out_ce      <= nxt_ce;
        out_ue      <= nxt_ue;
        out_err_pos <= nxt_pos;
      end
    end
  end

  // Clear beats a same-cycle increment; counts stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (cnt_clear) begin
      ce_count <= '0;
      ue_count <= '0;
    end else begin
      if (ld2 && nxt_ce && ce_count != '1)
        ce_count <= ce_count + CNT_W'(1);
      if (ld2 && nxt_ue && ue_count != '1)
        ue_count <= ue_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_decode_stage.sv
// Directed scoreboard bench for the SEC-DED decode stage.
// A second 3-bit-counter instance shares all inputs to reach saturation cheaply.
module tb_hamming_secded_decode_stage;
  import hamming_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        ce;
    logic        ue;
    logic [5:0]  pos;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [38:0] in_codeword = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_ce;
  logic        out_ue;
  logic [5:0]  out_err_pos;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        cnt_clear = 1'b0;
  logic [15:0] ce_count;
  logic [15:0] ue_count;

  logic        s_in_ready;
  logic [31:0] s_out_data;
  logic        s_out_ce;
  logic        s_out_ue;
  logic [5:0]  s_out_err_pos;
  logic        s_out_valid;
  logic [2:0]  s_ce_count;
  logic [2:0]  s_ue_count;

  hamming_secded_decode_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_codeword(in_codeword), .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data), .out_ce(out_ce), .out_ue(out_ue),
    .out_err_pos(out_err_pos), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clear(cnt_clear),
    .ce_count(ce_count), .ue_count(ue_count)
  );

  hamming_secded_decode_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_codeword(in_codeword), .in_valid(in_valid),
    .in_ready(s_in_ready),
    .out_data(s_out_data), .out_ce(s_out_ce), .out_ue(s_out_ue),
    .out_err_pos(s_out_err_pos), .out_valid(s_out_valid),
    .out_ready(out_ready), .cnt_clear(cnt_clear),
    .ce_count(s_ce_count), .ue_count(s_ue_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_ce = 0;
  int   exp_ue = 0;
  int   exp_ce_s = 0;
  int   exp_ue_s = 0;
  exp_t held;
  exp_t popped;
  logic stalled = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops on each transfer, checks hold under stall
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold", {out_data, out_ce, out_ue, out_err_pos}, held);
      stalled = out_valid && !out_ready;
      held = {out_data, out_ce, out_ue, out_err_pos};
      if (out_valid && out_ready) begin
        check("queue_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          popped = q.pop_front();
          check("word", {out_data, out_ce, out_ue, out_err_pos}, popped);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] d,
                              input int f1, input int f2);
    exp_t e;
    logic [31:0] raw;
    raw = d;
    for (int i = 0; i < 32; i++) begin
      if (data_pos(i) == f1 || data_pos(i) == f2) raw[i] = ~raw[i];
    end
    if (f1 < 0) e = '{data: d, ce: 1'b0, ue: 1'b0, pos: 6'd0};
    else if (f2 < 0) e = '{data: d, ce: 1'b1, ue: 1'b0, pos: 6'(f1)};
    else e = '{data: raw, ce: 1'b0, ue: 1'b1, pos: 6'd0};
    return e;
  endfunction

  function automatic logic [38:0] corrupt(input logic [31:0] d,
                                          input int f1, input int f2);
    logic [38:0] cw;
    cw = hamming_encode(d);
    if (f1 >= 0) cw[f1] = ~cw[f1];
    if (f2 >= 0) cw[f2] = ~cw[f2];
    return cw;
  endfunction

  // Call right after a negedge; returns at the negedge after acceptance
  task automatic send(input logic [38:0] cw, input exp_t e);
    int g = 0;
    in_codeword = cw;
    in_valid = 1'b1;
    #1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("accept_timeout", 64'(g < 50), 64'd1);
    q.push_back(e);
    if (e.ce && exp_ce < 65535) exp_ce++;
    if (e.ue && exp_ue < 65535) exp_ue++;
    if (e.ce && exp_ce_s < 7) exp_ce_s++;
    if (e.ue && exp_ue_s < 7) exp_ue_s++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic sendf(input logic [31:0] d, input int f1, input int f2);
    send(corrupt(d, f1, f2), mk(d, f1, f2));
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || out_valid) && g < 60) begin
      @(negedge clk);
      #3;
      g++;
    end
    check("drain_timeout", 64'(g < 60), 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_ce"}, 64'(ce_count), 64'(exp_ce));
    check({tag, "_ue"}, 64'(ue_count), 64'(exp_ue));
    check({tag, "_ce_sat"}, 64'(s_ce_count), 64'(exp_ce_s));
    check({tag, "_ue_sat"}, 64'(s_ue_count), 64'(exp_ue_s));
  endtask

  logic [31:0] w[4];

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", {out_valid, out_data, out_ce, out_ue, out_err_pos},
          64'd0);
    chk_cnt("reset");
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Clean word with latency check
    send(hamming_encode(32'h0000000F),
         '{data: 32'h0000000F, ce: 1'b0, ue: 1'b0, pos: 6'd0});
    #2;
    check("latency_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2;
    check("latency_c2", 64'(out_valid), 64'd1);
    check("clean_data", 64'(out_data), 64'h0000000F);
    drain();
    chk_cnt("clean");

    // Single errors
    send(corrupt(32'hDEADBEEF, 5, -1),
         '{data: 32'hDEADBEEF, ce: 1'b1, ue: 1'b0, pos: 6'd5});
    send(corrupt(32'hDEADBEEF, 0, -1),
         '{data: 32'hDEADBEEF, ce: 1'b1, ue: 1'b0, pos: 6'd0});
    sendf(32'hCAFEF00D, 38, -1);
    sendf(32'h00000000, 32, -1);
    drain();
    chk_cnt("single");

    // Double and out-of-range syndrome errors
    send(corrupt(32'h12345678, 3, 10),
         '{data: 32'h12345659, ce: 1'b0, ue: 1'b1, pos: 6'd0});
    sendf(32'h0BADF00D, 0, 7);
    send(corrupt(32'hA5A5A5A5, 32, 4) ^ 39'h8,
         '{data: 32'hA5A5A5A4, ce: 1'b0, ue: 1'b1, pos: 6'd0});
    drain();
    chk_cnt("double");

    // Backpressure
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    out_ready = 1'b0;
    fork
      begin
        sendf(w[0], -1, -1);
        sendf(w[1], 17, -1);
        sendf(w[2], -1, -1);
        sendf(w[3], 9, 22);
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_data", 64'(out_data), 64'(w[0]));
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk_cnt("bp");

    // Saturate the 3-bit counters
    for (int i = 0; i < 9; i++) sendf(32'h1000_0000 + i, 3 + i, -1);
    drain();
    chk_cnt("sat");

    // Clear coincident with a CE load into S2
    sendf(32'h55AA55AA, 12, -1);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    exp_ce = 0;
    exp_ue = 0;
    exp_ce_s = 0;
    exp_ue_s = 0;
    drain();
    chk_cnt("clear");
    sendf(32'h55AA55AB, 13, -1);
    drain();
    chk_cnt("after_clear");

    // Reset with two words in flight
    sendf(32'h11112222, 6, -1);
    sendf(32'h33334444, 7, -1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    exp_ce = 0;
    exp_ue = 0;
    exp_ce_s = 0;
    exp_ue_s = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    chk_cnt("rst");
    repeat (3) begin
      @(negedge clk);
      #1;
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    sendf(32'h76543210, 20, -1);
    drain();
    chk_cnt("recover");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
